mac_tx_frame_fifo: RTL and testbench
====================================

// Module: mac_tx_frame_fifo
// PURPOSE
//  Store-and-forward AXI-Stream frame FIFO that sits directly upstream of the MAC Tx user port.
//  The MAC aborts a frame (sends an error block) if tvalid drops mid-frame; this block removes that risk.
//  A frame is presented on the master side only once its tlast beat is stored, so tvalid never gaps mid-frame.
//  Sits in the Tx clock domain; the master side drives the MAC s00_axis_* inputs.
// PARAMETERS
//  DATA_WIDTH  64  tdata width in bits; tkeep width is DATA_WIDTH/8
//  DEPTH       64  storage depth in beats; power of two, >= 4
//  MAX_FRAMES  16  maximum complete frames held; sets frame-counter width
// PORTS
//  i_clk             in   1           Tx clock (the MAC i_txc)
//  i_reset_n         in   1           asynchronous, active-low reset
//  s00_axis_tdata    in   DATA_WIDTH  user write data
//  s00_axis_tkeep    in   DATA_WIDTH/8 byte enables; passed through unmodified
//  s00_axis_tvalid   in   1           write beat valid
//  s00_axis_tready   out  1           write beat accepted
//  s00_axis_tlast    in   1           last beat of frame
//  m00_axis_tdata    out  DATA_WIDTH  read data to MAC
//  m00_axis_tkeep    out  DATA_WIDTH/8 read byte enables
//  m00_axis_tvalid   out  1           read beat valid
//  m00_axis_tready   in   1           MAC ready
//  m00_axis_tlast    out  1           last beat of frame
//  o_frame_count     out  $clog2(MAX_FRAMES+1)  complete frames stored
//  o_drop            out  1           one-cycle pulse when a frame is discarded (macro only; tied 0 otherwise)
// BEHAVIOUR
//  Reset (async assert, sync-release use): wr_ptr, rd_ptr, frame_start and frame_count are 0; write FSM is W_IDLE.
//   During reset, all m00 outputs are 0, s00_axis_tready is 0, and o_drop is 0.
//   A reset asserted mid-frame discards all stored and partial data; no output glitch follows release.
//  Storage: DEPTH x {tlast, tkeep, tdata}. Pointers are $clog2(DEPTH)+1 bits and wrap naturally.
//   full  = (wr_ptr - rd_ptr) == DEPTH
//   empty = wr_ptr == rd_ptr
//  Write accept: beat = s00_axis_tvalid && s00_axis_tready.
//   tready = !full && (frame_count < MAX_FRAMES || in W_FRAME). A new frame may not start when MAX_FRAMES frames are held.
//  Write FSM:
//   W_IDLE -> W_FRAME on an accepted non-last beat; frame_start latches wr_ptr before the write.
//   W_IDLE stays in W_IDLE on an accepted last beat (single-beat frame).
//   W_FRAME -> W_IDLE on an accepted tlast beat.
//  frame_count: +1 on an accepted write tlast beat; -1 on a read handshake with m00_axis_tlast.
//   Simultaneous +1/-1 leaves it unchanged. It never exceeds MAX_FRAMES.
//  Read side is first-word-fall-through with a combinational read of mem[rd_ptr].
//   m00_axis_tvalid = (frame_count != 0). Output is zero-latency from the head word.
//   rd_ptr increments on tvalid && tready.
//   A frame's last beat becomes visible the cycle after its tlast write (frame_count registered).
//   Once tvalid rises for a frame, it stays high until that frame's tlast handshake, independent of the write side.
//   m00 data/keep/last may change only on a handshake.
//  Simultaneous read and write when full: the write is refused (tready computed from the registered full); the read proceeds.
//  Without TX_FIFO_DROP_OVERSIZE_EN: a full FIFO backpressures (tready=0).
//   Frames longer than DEPTH beats are unsupported: with frame_count==0 and full, the FIFO deadlocks by design.
// CONFIGURATION
//  TX_FIFO_DROP_OVERSIZE_EN defined:
//   In W_FRAME, tready is held at 1 even when full.
//   A beat arriving while full moves the FSM to W_DROP, rewinds wr_ptr to frame_start, and pulses o_drop once.
//   W_DROP accepts and discards beats; it moves to W_IDLE on an accepted tlast. frame_count is unchanged.
//   An oversize frame therefore never deadlocks, and stored complete frames are unaffected.
//  Not defined: W_DROP does not exist and o_drop is constant 0.
// STRUCTURE
//  Shared package mac_pkg:
//   tx_fifo_wr_state_t enum {W_IDLE, W_FRAME, W_DROP}
//   packed struct tx_fifo_word_t {tlast, tkeep, tdata} parameterised to 64-bit
//   localparam TX_FIFO_DEPTH_DEFAULT
//  One sub-module: sdp_ram (simple dual-port, sync write, async read, WIDTH/DEPTH parameters).
//  Pointer, FSM and counter logic live in this module.
// TESTING
//  1. Write a 3-beat frame (keep FF,FF,0F) with m00_tready=1.
//     -> m00_tvalid rises 1 cycle after the tlast write.
//     -> 3 beats are contiguous and identical; tlast is on beat 3; frame_count goes 1 -> 0.
//  2. Write 2 beats, stall s00_tvalid 10 cycles, then write the tlast beat.
//     -> m00_tvalid stays 0 throughout the stall and rises only after tlast; no gaps on output.
//  3. DEPTH=8: write five 1-beat frames with m00_tready=0, then raise tready.
//     -> frame_count reaches 5; 5 beats drain back to back, each with tlast=1; count returns to 0.
//  4. DEPTH=8, MAX_FRAMES=2: write 2 frames, then offer a third.
//     -> tready=0 until one frame drains.
//     -> On the same cycle, a write-tlast plus read-tlast holds frame_count constant.
//  5. Macro on, DEPTH=8: hold one 2-beat frame, then write a 10-beat frame.
//     -> o_drop pulses exactly once; the dropped frame's beats are still accepted.
//     -> Only the 2-beat frame appears on output.
//     -> The following 3-beat frame is delivered intact.
//  6. Assert i_reset_n=0 mid-write with 1 frame queued.
//     -> Outputs go to 0 immediately (async) and frame_count=0.
//     -> After release, the next frame is delivered alone and correctly.

Source files
------------

// File: rtl/mac_tx_frame_fifo_pkg.sv
// Shared types and defaults for the MAC Tx store-and-forward frame FIFO.
package mac_pkg;

  localparam int TX_FIFO_DEPTH_DEFAULT      = 64;
  localparam int TX_FIFO_DATA_W             = 64;
  localparam int TX_FIFO_MAX_FRAMES_DEFAULT = 16;

  // Write-side frame tracking. W_DROP is only reachable with oversize dropping enabled.
  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FRAME = 2'd1,
    W_DROP  = 2'd2
  } tx_fifo_wr_state_t;

  // One stored beat, laid out exactly as it is packed into the RAM.
  typedef struct packed {
    logic                        tlast;
    logic [TX_FIFO_DATA_W/8-1:0] tkeep;
    logic [TX_FIFO_DATA_W-1:0]   tdata;
  } tx_fifo_word_t;

endpackage

// File: rtl/mac_tx_frame_fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous (combinational) read.
module sdp_ram #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_tx_frame_fifo.sv
// Store-and-forward AXI-Stream frame FIFO feeding the MAC Tx user port.
// A frame is only offered downstream once its tlast beat is stored, so the
// MAC never sees tvalid drop mid-frame.
// Optional build macro TX_FIFO_DROP_OVERSIZE_EN: frames that overflow the
// storage are discarded (o_drop pulses) instead of backpressuring forever.
import mac_pkg::*;

module mac_tx_frame_fifo #(
  parameter int DATA_WIDTH = TX_FIFO_DATA_W,
  parameter int DEPTH      = TX_FIFO_DEPTH_DEFAULT,
  parameter int MAX_FRAMES = TX_FIFO_MAX_FRAMES_DEFAULT
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic [DATA_WIDTH-1:0]             s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]           s00_axis_tkeep,
  input  logic                              s00_axis_tvalid,
  output logic                              s00_axis_tready,
  input  logic                              s00_axis_tlast,
  output logic [DATA_WIDTH-1:0]             m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m00_axis_tkeep,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  output logic                              m00_axis_tlast,
  output logic [$clog2(MAX_FRAMES+1)-1:0]   o_frame_count,
  output logic                              o_drop
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_FRAMES + 1);
  localparam int WW = 1 + KW + DATA_WIDTH;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_FRAMES);

  tx_fifo_wr_state_t state_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     frame_count_q;
  logic              en_q;

  logic              full_s;
  logic              room_s;
  logic              tready_s;
  logic              wr_beat_s;
  logic              wr_en_s;
  logic              wr_last_s;
  logic              tvalid_s;
  logic              rd_beat_s;
  logic              rd_last_beat_s;
  logic [WW-1:0]     rd_word_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_s = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign room_s = (frame_count_q < CNT_MAX);

  // Write-side ready: no new frame may start once MAX_FRAMES are held.
  always_comb begin
    tready_s = 1'b0;
`ifdef TX_FIFO_DROP_OVERSIZE_EN
    if ((state_q == W_FRAME) || (state_q == W_DROP)) begin
      tready_s = en_q;
    end else begin
      tready_s = en_q && !full_s && room_s;
    end
`else
    if (state_q == W_FRAME) begin
      tready_s = en_q && !full_s;
    end else begin
      tready_s = en_q && !full_s && room_s;
    end
`endif
  end

  assign wr_beat_s = s00_axis_tvalid && tready_s;
  // A beat arriving while full (drop build only) or while discarding is never stored.
  assign wr_en_s   = wr_beat_s && !full_s && (state_q != W_DROP);
  assign wr_last_s = wr_en_s && s00_axis_tlast;

  assign tvalid_s       = (frame_count_q != {CW{1'b0}});
  assign rd_beat_s      = tvalid_s && m00_axis_tready;
  assign rd_last_beat_s = rd_beat_s && rd_word_s[WW-1];

  sdp_ram #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (i_clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata}),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_word_s)
  );

`ifdef TX_FIFO_DROP_OVERSIZE_EN
  logic [PW-1:0] frame_start_q;
  logic          drop_q;

  // Write FSM: tracks frame boundaries, rewinds and discards oversize frames.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= W_IDLE;
      wr_ptr_q      <= {PW{1'b0}};
      frame_start_q <= {PW{1'b0}};
      drop_q        <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (wr_beat_s) begin
        case (state_q)
          W_IDLE: begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (!s00_axis_tlast) begin
              state_q       <= W_FRAME;
              frame_start_q <= wr_ptr_q;
            end
          end
          W_FRAME: begin
            if (full_s) begin
              // Throw away the partial frame; completed frames stay intact.
              wr_ptr_q <= frame_start_q;
              drop_q   <= 1'b1;
              state_q  <= s00_axis_tlast ? W_IDLE : W_DROP;
            end else begin
              wr_ptr_q <= wr_ptr_q + PTR_ONE;
              if (s00_axis_tlast) begin
                state_q <= W_IDLE;
              end
            end
          end
          W_DROP: begin
            if (s00_axis_tlast) begin
              state_q <= W_IDLE;
            end
          end
          default: state_q <= W_IDLE;
        endcase
      end
    end
  end

  assign o_drop = drop_q;
`else
  // Write FSM: tracks frame boundaries so a new frame only starts with room for it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= W_IDLE;
      wr_ptr_q <= {PW{1'b0}};
    end else begin
      if (wr_beat_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        case (state_q)
          W_IDLE: begin
            if (!s00_axis_tlast) begin
              state_q <= W_FRAME;
            end
          end
          W_FRAME: begin
            if (s00_axis_tlast) begin
              state_q <= W_IDLE;
            end
          end
          default: state_q <= W_IDLE;
        endcase
      end
    end
  end

  assign o_drop = 1'b0;
`endif

  // Read pointer advances on every output handshake.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q <= {PW{1'b0}};
    end else if (rd_beat_s) begin
      rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Complete-frame count: up on a stored tlast, down on a delivered tlast.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      frame_count_q <= {CW{1'b0}};
    end else begin
      case ({wr_last_s, rd_last_beat_s})
        2'b10:   frame_count_q <= frame_count_q + CNT_ONE;
        2'b01:   frame_count_q <= frame_count_q - CNT_ONE;
        default: frame_count_q <= frame_count_q;
      endcase
    end
  end

  // Holds s00 ready low while reset is asserted and for the first cycle after release.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  // Output beat fields are masked while nothing is offered so reset and idle read as zero.
  assign s00_axis_tready = tready_s;
  assign m00_axis_tvalid = tvalid_s;
  assign m00_axis_tdata  = tvalid_s ? rd_word_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
  assign m00_axis_tkeep  = tvalid_s ? rd_word_s[DATA_WIDTH +: KW] : {KW{1'b0}};
  assign m00_axis_tlast  = tvalid_s && rd_word_s[WW-1];
  assign o_frame_count   = frame_count_q;

endmodule

// File: tb/tb_mac_tx_frame_fifo.sv
// Self-checking bench for mac_tx_frame_fifo: two DEPTH=8 instances
// (MAX_FRAMES=16 and MAX_FRAMES=2) share stimulus; a scoreboard queue holds
// the beats expected on the selected instance's master side.
module tb_mac_tx_frame_fifo;

  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int CWA = $clog2(17);
  localparam int CWB = $clog2(3);

  typedef logic [72:0] word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [DW-1:0] s_tdata  = 64'h0;
  logic [KW-1:0] s_tkeep  = 8'h0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic          m_tready = 1'b0;

  logic           a_tready, a_tvalid, a_tlast, a_drop;
  logic [DW-1:0]  a_tdata;
  logic [KW-1:0]  a_tkeep;
  logic [CWA-1:0] a_count;
  logic           b_tready, b_tvalid, b_tlast, b_drop;
  logic [DW-1:0]  b_tdata;
  logic [KW-1:0]  b_tkeep;
  logic [CWB-1:0] b_count;

  logic           sel = 1'b0;
  logic           sel_tready, sel_tvalid, sel_tlast, sel_drop;
  logic [DW-1:0]  sel_tdata;
  logic [KW-1:0]  sel_tkeep;
  logic [4:0]     sel_count;

  int    cmp = 0;
  int    err = 0;
  word_t sb[$];
  bit    in_frame = 1'b0;
  bit    last_acc = 1'b0;
  int    pops = 0;
  int    drops = 0;

  always #5 clk = ~clk;

  mac_tx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .MAX_FRAMES(16)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n),
    .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(a_tready), .s00_axis_tlast(s_tlast),
    .m00_axis_tdata(a_tdata), .m00_axis_tkeep(a_tkeep), .m00_axis_tvalid(a_tvalid),
    .m00_axis_tready(m_tready), .m00_axis_tlast(a_tlast),
    .o_frame_count(a_count), .o_drop(a_drop)
  );

  mac_tx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .MAX_FRAMES(2)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n),
    .s00_axis_tdata(s_tdata), .s00_axis_tkeep(s_tkeep), .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(b_tready), .s00_axis_tlast(s_tlast),
    .m00_axis_tdata(b_tdata), .m00_axis_tkeep(b_tkeep), .m00_axis_tvalid(b_tvalid),
    .m00_axis_tready(m_tready), .m00_axis_tlast(b_tlast),
    .o_frame_count(b_count), .o_drop(b_drop)
  );

  // Route the instance under test to a common set of observation signals.
  always_comb begin
    if (sel) begin
      sel_tready = b_tready; sel_tvalid = b_tvalid; sel_tlast = b_tlast; sel_drop = b_drop;
      sel_tdata  = b_tdata;  sel_tkeep  = b_tkeep;  sel_count = 5'(b_count);
    end else begin
      sel_tready = a_tready; sel_tvalid = a_tvalid; sel_tlast = a_tlast; sel_drop = a_drop;
      sel_tdata  = a_tdata;  sel_tkeep  = a_tkeep;  sel_count = 5'(a_count);
    end
  end

  // One clock: sample at the falling edge, check output beats against the scoreboard.
  task automatic tick();
    word_t exp_w;
    @(negedge clk);
    last_acc = s_tvalid && sel_tready;
    drops    = drops + int'(sel_drop);
`ifndef TX_FIFO_DROP_OVERSIZE_EN
    cmp++;
    if (sel_drop !== 1'b0) begin
      err++; $display("FAIL drop_tied got %b want 0", sel_drop);
    end
`endif
    if (sel_tvalid && m_tready) begin
      cmp++; pops++;
      if (sb.size() == 0) begin
        err++; $display("FAIL unexpected_beat got %h want none", {sel_tlast, sel_tkeep, sel_tdata});
      end else begin
        exp_w = sb.pop_front();
        if ({sel_tlast, sel_tkeep, sel_tdata} !== exp_w) begin
          err++; $display("FAIL out_beat got %h want %h", {sel_tlast, sel_tkeep, sel_tdata}, exp_w);
        end
      end
      in_frame = !sel_tlast;
    end else if (in_frame) begin
      cmp++;
      if (sel_tvalid !== 1'b1) begin
        err++; $display("FAIL tvalid_gap got %b want 1", sel_tvalid);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one input beat until accepted; record it as expected output when e is set.
  task automatic put(input logic [63:0] d, input logic [7:0] k, input logic l, input bit e);
    int n;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 50);
    if (!last_acc) begin
      cmp++; err++; $display("FAIL put_timeout got tready=0 want 1 data %h", d);
    end else if (e) begin
      sb.push_back({l, k, d});
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int n_max);
    int t;
    t = 0;
    while (sb.size() != 0 && t < n_max) begin tick(); t++; end
    cmp++;
    if (sb.size() != 0) begin
      err++; $display("FAIL drain_timeout got %0d left want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    sb.delete(); in_frame = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic check_count(input string name, input int want);
    cmp++;
    if (int'(sel_count) != want) begin
      err++; $display("FAIL %s got %0d want %0d", name, sel_count, want);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    cmp++;
    if ({a_tvalid, a_tlast, a_tdata, a_tkeep, a_tready, a_drop, b_tready, b_tvalid} !== 80'h0) begin
      err++; $display("FAIL reset_outputs got %h want 0",
                      {a_tvalid, a_tlast, a_tdata, a_tkeep, a_tready, a_drop, b_tready, b_tvalid});
    end
    check_count("reset_count", 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(); tick();
    check_count("post_reset_count", 0);
    cmp++;
    if (a_tvalid !== 1'b0 || a_tready !== 1'b1) begin
      err++; $display("FAIL post_reset_hs got v=%b r=%b want v=0 r=1", a_tvalid, a_tready);
    end
  endtask

  task automatic test_single_frame();
    sel = 1'b0; do_reset(); m_tready = 1'b1;
    put(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 1'b1);
    put(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 1'b1);
    cmp++;
    if (sel_tvalid !== 1'b0) begin err++; $display("FAIL early_tvalid got %b want 0", sel_tvalid); end
    put(64'h1111_0000_0000_0003, 8'h0F, 1'b1, 1'b1);
    cmp++;
    if (sel_tvalid !== 1'b1) begin err++; $display("FAIL tvalid_rise got %b want 1", sel_tvalid); end
    check_count("single_count_1", 1);
    pops = 0;
    tick(); tick(); tick();
    cmp++;
    if (pops != 3) begin err++; $display("FAIL single_contig got %0d want 3", pops); end
    check_count("single_count_0", 0);
  endtask

  task automatic test_stall();
    sel = 1'b0; do_reset(); m_tready = 1'b1;
    put(64'h2222_0000_0000_0001, 8'hFF, 1'b0, 1'b1);
    put(64'h2222_0000_0000_0002, 8'hFF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      cmp++;
      if (sel_tvalid !== 1'b0) begin err++; $display("FAIL stall_tvalid got %b want 0", sel_tvalid); end
    end
    put(64'h2222_0000_0000_0003, 8'h3F, 1'b1, 1'b1);
    drain(20);
    check_count("stall_count", 0);
  endtask

  task automatic test_multi_frames();
    sel = 1'b0; do_reset(); m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(64'h3333_0000_0000_0000 + 64'(i), 8'h01 << i, 1'b1, 1'b1);
    end
    check_count("multi_count_5", 5);
    m_tready = 1'b1; pops = 0;
    repeat (5) tick();
    cmp++;
    if (pops != 5) begin err++; $display("FAIL multi_b2b got %0d want 5", pops); end
    check_count("multi_count_0", 0);
  endtask

  task automatic test_max_frames();
    sel = 1'b1; do_reset(); m_tready = 1'b0;
    put(64'h4444_0000_0000_0001, 8'hFF, 1'b1, 1'b1);
    put(64'h4444_0000_0000_0002, 8'hFF, 1'b1, 1'b1);
    check_count("max_count_2", 2);
    s_tdata = 64'h4444_0000_0000_00A0; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp++;
      if (last_acc !== 1'b0 || sel_tready !== 1'b0) begin
        err++; $display("FAIL max_block got tready=%b want 0", sel_tready);
      end
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    cmp++;
    if (sel_tready !== 1'b1) begin err++; $display("FAIL max_unblock got %b want 1", sel_tready); end
    check_count("max_count_1", 1);
    put(64'h4444_0000_0000_00A0, 8'hFF, 1'b0, 1'b1);
    m_tready = 1'b1;
    put(64'h4444_0000_0000_00B0, 8'h07, 1'b1, 1'b1);
    check_count("max_simul_count", 1);
    drain(20);
    check_count("max_count_0", 0);
  endtask

`ifdef TX_FIFO_DROP_OVERSIZE_EN
  task automatic test_drop();
    sel = 1'b0; do_reset(); m_tready = 1'b0; drops = 0;
    put(64'h5555_0000_0000_0001, 8'hFF, 1'b0, 1'b1);
    put(64'h5555_0000_0000_0002, 8'h0F, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      put(64'h5555_0000_0000_0100 + 64'(i), 8'hFF, (i == 9), 1'b0);
    end
    tick();
    cmp++;
    if (drops != 1) begin err++; $display("FAIL drop_pulses got %0d want 1", drops); end
    check_count("drop_count_1", 1);
    put(64'h5555_0000_0000_0201, 8'hFF, 1'b0, 1'b1);
    put(64'h5555_0000_0000_0202, 8'hFF, 1'b0, 1'b1);
    put(64'h5555_0000_0000_0203, 8'h01, 1'b1, 1'b1);
    check_count("drop_count_2", 2);
    m_tready = 1'b1;
    drain(20);
    check_count("drop_count_0", 0);
  endtask
`endif

  task automatic test_reset_mid();
    sel = 1'b0; do_reset(); m_tready = 1'b0;
    put(64'h6666_0000_0000_0001, 8'hFF, 1'b1, 1'b1);
    s_tdata = 64'h6666_0000_0000_0002; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
    tick();
    check_count("mid_count_1", 1);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({a_tvalid, a_tlast, a_tdata, a_tkeep, a_tready} !== 75'h0) begin
      err++; $display("FAIL mid_reset_outputs got %h want 0", {a_tvalid, a_tlast, a_tdata, a_tkeep, a_tready});
    end
    check_count("mid_reset_count", 0);
    sb.delete(); in_frame = 1'b0; s_tvalid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    m_tready = 1'b1;
    put(64'h6666_0000_0000_0010, 8'hFF, 1'b0, 1'b1);
    put(64'h6666_0000_0000_0011, 8'h03, 1'b1, 1'b1);
    drain(20);
    check_count("mid_after_count", 0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_multi_frames();
    test_max_frames();
`ifdef TX_FIFO_DROP_OVERSIZE_EN
    test_drop();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
